// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O port responder: PORT_OUT, PORT_IN, STATUS and change
// counter behind a 16-byte window, with configurable wait states.
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Ready,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam logic [2:0] WAIT_INIT =
      (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_t      state;
   state_t      stateNext;
   logic [2:0]  waitCnt;
   logic [1:0]  capOff;
   logic [31:0] capData;
   logic        capWrite;
   logic [7:0]  syncA;
   logic [7:0]  syncIn;
   logic [7:0]  prevIn;
   logic        chg;
   logic        err;
   logic [15:0] count16;
   logic        sel;
   logic        take;
   logic        errSet;
   logic        statClr;
   logic        chgEv;
   logic [31:0] regVal;

   assign sel = (Address[31:4] == BASE_ADDR[31:4]) && (MemRead || MemWrite);
   assign take = (state == IDLE) && sel;
   assign errSet = take && MemRead && MemWrite;
   assign statClr = (state == RESP) && !capWrite && (capOff == 2'd2);
   assign chgEv = (syncIn != prevIn);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: begin
            if (sel) begin
               stateNext = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (waitCnt == 3'd0) begin
               stateNext = RESP;
            end
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Request fields are captured once and frozen until RESP completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         waitCnt  <= 3'd0;
         capOff   <= 2'd0;
         capData  <= 32'h0;
         capWrite <= 1'b0;
      end else if (take) begin
         waitCnt  <= WAIT_INIT;
         capOff   <= Address[3:2];
         capData  <= WriteData;
         capWrite <= MemWrite;
      end else if (state == WAIT && waitCnt != 3'd0) begin
         waitCnt <= waitCnt - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PortOut <= 32'h0;
      end else if (state == RESP && capWrite && capOff == 2'd0) begin
         PortOut <= capData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncA  <= 8'h0;
         syncIn <= 8'h0;
         prevIn <= 8'h0;
      end else begin
         syncA  <= PortIn;
         syncIn <= syncA;
         prevIn <= syncIn;
      end
   end

   // A set event in the clearing cycle wins over clear-on-read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chg     <= 1'b0;
         err     <= 1'b0;
         count16 <= 16'h0;
      end else begin
         chg <= chgEv || (chg && !statClr);
         err <= errSet || (err && !statClr);
         if (chgEv) begin
            count16 <= count16 + 16'd1;
         end
      end
   end

   always_comb begin
      regVal = 32'h0;
      unique case (capOff)
         2'd0:    regVal = PortOut;
         2'd1:    regVal = {24'h0, syncIn};
         2'd2:    regVal = {30'h0, err, chg};
         2'd3:    regVal = {16'h0, count16};
         default: regVal = 32'h0;
      endcase
   end

   always_comb begin
      Ready    = (state == RESP);
      ReadData = 32'h0;
      if (state == RESP && !capWrite) begin
         ReadData = regVal;
      end
   end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed and random accesses against
// a register-level reference model, plus a WAIT_STATES=3 reset-abort case.
module tb_mmio_port_responder;

   localparam logic [31:0] BASE = 32'hFFFF0000;
   localparam int WS = 1;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Ready;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;

   logic        rst3;
   logic [31:0] addr3;
   logic [31:0] wd3;
   logic        mw3;
   logic        mr3;
   logic [31:0] rd3;
   logic        rdy3;
   logic [7:0]  pin3;
   logic [31:0] po3;

   int nChk;
   int nFail;

   // reference model state
   logic [31:0] mPortOut;
   logic [7:0]  mS1;
   logic [7:0]  mSync;
   logic [7:0]  mPrev;
   logic        mChg;
   logic        mErr;
   logic [15:0] mCount;
   logic        clrFlag;
   logic        errFlag;
   logic        wrFlag;
   logic [31:0] wrVal;

   mmio_port_responder #(.BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .Address(Address),
      .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
      .ReadData(ReadData), .Ready(Ready), .PortIn(PortIn),
      .PortOut(PortOut)
   );

   mmio_port_responder #(.BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(rst3), .Address(addr3),
      .WriteData(wd3), .MemWrite(mw3), .MemRead(mr3),
      .ReadData(rd3), .Ready(rdy3), .PortIn(pin3),
      .PortOut(po3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nChk++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: model applies clear, then set events, then shifts pins.
   task automatic cyc();
      logic [7:0] pin;
      logic ev;
      pin = PortIn;
      @(posedge clk);
      ev = (mSync != mPrev);
      if (clrFlag) begin
         mChg = 1'b0;
         mErr = 1'b0;
      end
      if (ev) begin
         mChg = 1'b1;
         mCount = mCount + 16'd1;
      end
      if (errFlag) mErr = 1'b1;
      if (wrFlag) mPortOut = wrVal;
      mPrev = mSync;
      mSync = mS1;
      mS1 = pin;
      clrFlag = 1'b0;
      errFlag = 1'b0;
      wrFlag = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [31:0] modelReg(input logic [1:0] off);
      case (off)
         2'd0:    return mPortOut;
         2'd1:    return {24'h0, mSync};
         2'd2:    return {30'h0, mErr, mChg};
         default: return {16'h0, mCount};
      endcase
   endfunction

   task automatic access(input logic [31:0] addr, input logic [31:0] wd,
                         input logic rd, input logic wr,
                         input logic [7:0] pin, input string tag);
      logic        sel;
      logic [1:0]  off;
      logic [31:0] exp;
      Address = addr;
      WriteData = wd;
      MemRead = rd;
      MemWrite = wr;
      PortIn = pin;
      sel = (addr[31:4] == BASE[31:4]) && (rd || wr);
      off = addr[3:2];
      if (!sel) begin
         for (int i = 0; i < 10; i++) begin
            cyc();
            check({tag, "-noready"}, 32'(Ready), 32'h0);
         end
         check({tag, "-portout"}, PortOut, mPortOut);
         MemRead = 1'b0;
         MemWrite = 1'b0;
         return;
      end
      errFlag = rd && wr;
      cyc();
      for (int i = 0; i < WS; i++) begin
         check({tag, "-early"}, 32'(Ready), 32'h0);
         cyc();
      end
      check({tag, "-ready"}, 32'(Ready), 32'h1);
      exp = wr ? 32'h0 : modelReg(off);
      check({tag, "-rdata"}, ReadData, exp);
      if (wr && off == 2'd0) begin
         wrFlag = 1'b1;
         wrVal = wd;
      end
      if (!wr && off == 2'd2) clrFlag = 1'b1;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      Address = $urandom;
      cyc();
      check({tag, "-pulse"}, 32'(Ready), 32'h0);
      check({tag, "-rdzero"}, ReadData, 32'h0);
      check({tag, "-portout"}, PortOut, mPortOut);
   endtask

   initial begin
      int steps;
      logic [1:0] off;
      logic rd;
      logic wr;
      logic [7:0] pin;
      nChk = 0;
      nFail = 0;
      mPortOut = 0; mS1 = 0; mSync = 0; mPrev = 0;
      mChg = 0; mErr = 0; mCount = 0;
      clrFlag = 0; errFlag = 0; wrFlag = 0; wrVal = 0;
      reset = 1'b0; rst3 = 1'b0;
      Address = 0; WriteData = 0; MemWrite = 0; MemRead = 0; PortIn = 0;
      addr3 = 0; wd3 = 0; mw3 = 0; mr3 = 0; pin3 = 0;
      repeat (3) @(negedge clk);
      check("rst-ready", 32'(Ready), 32'h0);
      check("rst-rdata", ReadData, 32'h0);
      check("rst-portout", PortOut, 32'h0);
      check("rst3-portout", po3, 32'h0);
      reset = 1'b1;
      rst3 = 1'b1;
      cyc();

      access(32'hFFFF0000, 32'hDEADBEEF, 0, 1, 8'h00, "wr-port");
      check("wr-port-val", PortOut, 32'hDEADBEEF);
      access(32'hFFFF0003, 32'h0, 1, 0, 8'h00, "rd-port");
      access(32'hFFFF000C, 32'h0, 1, 0, 8'h00, "rd-cnt0");

      PortIn = 8'h5A;
      repeat (3) cyc();
      access(32'hFFFF0004, 32'h0, 1, 0, 8'h5A, "rd-pin");
      access(32'hFFFF0008, 32'h0, 1, 0, 8'h5A, "rd-stat1");
      access(32'hFFFF0008, 32'h0, 1, 0, 8'h5A, "rd-stat2");
      access(32'hFFFF000C, 32'h0, 1, 0, 8'h5A, "rd-cnt1");
      access(32'hFFFF0004, 32'h1234, 0, 1, 8'h5A, "wr-ro");

      access(32'hFFFF0000, 32'h1, 1, 1, 8'h5A, "both");
      check("both-val", PortOut, 32'h1);
      access(32'hFFFF0008, 32'h0, 1, 0, 8'h5A, "rd-err");
      access(32'h10010000, 32'h0, 1, 0, 8'h5A, "unsel");
      check("unsel-portout", PortOut, 32'h1);

      access(32'hFFFF0008, 32'h0, 1, 0, 8'h5A, "clr");
      access(32'hFFFF0008, 32'h0, 1, 0, 8'hA5, "coinc");
      access(32'hFFFF0008, 32'h0, 1, 0, 8'hA5, "coinc-after");

      for (int n = 0; n < 60; n++) begin
         pin = ($urandom_range(0, 2) == 0) ? 8'($urandom) : PortIn;
         if ($urandom_range(0, 9) == 0) begin
            access(32'h10010000 | ($urandom & 32'hFFFF), $urandom,
                   1'($urandom), 1'b1, pin, "rnd-unsel");
         end else begin
            off = 2'($urandom);
            wr = 1'($urandom);
            rd = !wr || ($urandom_range(0, 4) == 0);
            access({BASE[31:4], off, 2'($urandom)}, $urandom,
                   rd, wr, pin, "rnd");
         end
         repeat ($urandom_range(0, 3)) begin
            if ($urandom_range(0, 1) == 0) PortIn = 8'($urandom);
            cyc();
         end
      end

      repeat (3) cyc();
      steps = 32'hFFFF - int'(mCount);
      for (int i = 0; i < steps; i++) begin
         PortIn = ~PortIn;
         cyc();
      end
      repeat (3) cyc();
      access(32'hFFFF000C, 32'h0, 1, 0, PortIn, "cnt-ffff");
      PortIn = ~PortIn;
      repeat (3) cyc();
      access(32'hFFFF000C, 32'h0, 1, 0, PortIn, "cnt-wrap");

      addr3 = 32'hFFFF0000;
      wd3 = 32'h77;
      mw3 = 1'b1;
      cyc();
      cyc();
      check("ws3-wait", 32'(rdy3), 32'h0);
      rst3 = 1'b0;
      #1;
      check("ws3-abort-rdy", 32'(rdy3), 32'h0);
      check("ws3-abort-po", po3, 32'h0);
      mw3 = 1'b0;
      @(negedge clk);
      rst3 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("ws3-idle-rdy", 32'(rdy3), 32'h0);
         check("ws3-idle-po", po3, 32'h0);
      end
      wd3 = 32'h55;
      mw3 = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         check("ws3-early", 32'(rdy3), 32'h0);
         cyc();
      end
      check("ws3-ready", 32'(rdy3), 32'h1);
      mw3 = 1'b0;
      cyc();
      check("ws3-pulse", 32'(rdy3), 32'h0);
      check("ws3-po", po3, 32'h55);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChk, nFail);
      $finish;
   end

endmodule
